// File: rtl/conv_pkg.sv
// Shared constants, state encoding and tap geometry for the convolution window fetcher.
package conv_pkg;

    localparam int IMG_W    = 64;
    localparam int IMG_LOG2 = 6;
    localparam int ADDR_W   = 12;
    localparam int TAPS     = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } fetchStateT;

    // Row/column offset of each tap relative to the centre pixel, tap k = 3*(dr+1) + (dc+1).
    localparam int TAP_DR [TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    localparam int TAP_DC [TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

    localparam logic [IMG_LOG2-1:0] EDGE_MAX = IMG_LOG2'(IMG_W - 1);

    // Tag carried alongside each issued read until its data returns.
    typedef struct packed {
        logic       live;
        logic [3:0] tap;
        logic       pad;
    } tapTagT;

    function automatic logic isPadTap(input logic [3:0] k,
                                      input logic [IMG_LOG2-1:0] row,
                                      input logic [IMG_LOG2-1:0] col);
        logic padOut;
        padOut = 1'b0;
        if (k <= 4'(TAPS - 1)) begin
            padOut = (row == '0       && TAP_DR[k] < 0) ||
                     (row == EDGE_MAX && TAP_DR[k] > 0) ||
                     (col == '0       && TAP_DC[k] < 0) ||
                     (col == EDGE_MAX && TAP_DC[k] > 0);
        end
        return padOut;
    endfunction

endpackage

// File: rtl/conv_window_fetch_if.sv
// Controller/RAM-facing bundle of the window fetcher; slave = fetcher, master = controller + RAM.
interface conv_window_fetch_if #(
    parameter int DATA_W = 16
);
    import conv_pkg::*;

    // Handshake: i_start is a request sampled only while the fetcher is idle (no ready is
    // returned; starts seen while busy are dropped). o_valid is a single-cycle completion
    // strobe, and o_window is stable from that strobe until the next accepted start.
    logic                     i_start;
    logic [108:0]             i_addrRead;
    logic [ADDR_W-1:0]        i_localAddr;
    logic [ADDR_W-1:0]        o_ramAddr;
    logic                     o_ramRdEn;
    logic [DATA_W-1:0]        i_ramData;
    logic [DATA_W*TAPS-1:0]   o_window;
    logic                     o_valid;
    logic                     o_busy;
    fetchStateT               dbgState;

    modport slave (
        input  i_start, i_addrRead, i_localAddr, i_ramData,
        output o_ramAddr, o_ramRdEn, o_window, o_valid, o_busy, dbgState
    );

    modport master (
        output i_start, i_addrRead, i_localAddr, i_ramData,
        input  o_ramAddr, o_ramRdEn, o_window, o_valid, o_busy, dbgState
    );

endinterface

// File: rtl/conv_window_delay.sv
// Shift register that follows each issued read through the RAM latency so its data
// can be steered to the right tap slot when it returns.
module conv_window_delay
    import conv_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   i_clk,
    input  logic   i_reset,
    input  tapTagT inTag,
    output tapTagT outTag
);

    tapTagT stages [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= inTag;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign outTag = stages[DEPTH-1];

endmodule

// File: rtl/conv_window_fetch.sv
// Fetches a 3x3 neighbourhood with nine sequential RAM reads and returns it as one packed window.
// Optional boundary zero-padding is enabled by defining CONV_WINDOW_PAD_EN.
module conv_window_fetch
    import conv_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RAM_LAT = 1
) (
    input logic               i_clk,
    input logic               i_reset,
    conv_window_fetch_if.slave bus
);

    fetchStateT               state;
    fetchStateT               nextState;
    logic [3:0]               tapCnt;
    logic [2:0]               drainCnt;
    logic [ADDR_W-1:0]        tapAddr [TAPS];
    logic [DATA_W*TAPS-1:0]   window;
    logic                     valid;
    logic                     busy;

    logic [ADDR_W-1:0]        ramAddr;
    logic                     ramRdEn;
    logic                     tapPad;
    tapTagT                   issueTag;
    tapTagT                   returnTag;
    logic                     startAccept;
    logic                     unusedBits;

    assign startAccept = (state == IDLE) && bus.i_start;

`ifdef CONV_WINDOW_PAD_EN
    logic [ADDR_W-1:0] centreAddr;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            centreAddr <= '0;
        end else if (startAccept) begin
            centreAddr <= bus.i_localAddr;
        end
    end

    assign unusedBits = bus.i_addrRead[108];
`else
    assign unusedBits = ^{bus.i_addrRead[108], bus.i_localAddr};
`endif

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (bus.i_start) nextState = ISSUE;
            ISSUE:   if (tapCnt == 4'(TAPS - 1)) nextState = DRAIN;
            DRAIN:   if (drainCnt == 3'(RAM_LAT - 1)) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // RAM bus is driven straight from state and tap counter so tap k appears in cycle k+1.
    always_comb begin
        ramAddr  = '0;
        ramRdEn  = 1'b0;
        tapPad   = 1'b0;
        issueTag = '0;
        if (state == ISSUE) begin
`ifdef CONV_WINDOW_PAD_EN
            tapPad = isPadTap(tapCnt, centreAddr[ADDR_W-1:IMG_LOG2], centreAddr[IMG_LOG2-1:0]);
`endif
            ramAddr       = tapAddr[tapCnt];
            ramRdEn       = !tapPad;
            issueTag.live = 1'b1;
            issueTag.tap  = tapCnt;
            issueTag.pad  = tapPad;
        end
    end

    conv_window_delay #(
        .DEPTH (RAM_LAT)
    ) u_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .inTag   (issueTag),
        .outTag  (returnTag)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= IDLE;
            tapCnt   <= '0;
            drainCnt <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= nextState;
            tapCnt   <= (state == ISSUE) ? tapCnt + 4'd1 : 4'd0;
            drainCnt <= (state == DRAIN) ? drainCnt + 3'd1 : 3'd0;
            valid    <= (nextState == DONE);
            busy     <= (nextState == ISSUE) || (nextState == DRAIN);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < TAPS; k++) begin
                tapAddr[k] <= '0;
            end
        end else if (startAccept) begin
            for (int k = 0; k < TAPS; k++) begin
                tapAddr[k] <= bus.i_addrRead[ADDR_W*k +: ADDR_W];
            end
        end
    end

    // Returning reads land in their tap slot; a fresh start wipes the previous window.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            window <= '0;
        end else if (startAccept) begin
            window <= '0;
        end else if (returnTag.live) begin
            for (int k = 0; k < TAPS; k++) begin
                if (returnTag.tap == 4'(k)) begin
                    window[DATA_W*k +: DATA_W] <= returnTag.pad ? '0 : bus.i_ramData;
                end
            end
        end
    end

    assign bus.o_ramAddr  = ramAddr;
    assign bus.o_ramRdEn  = ramRdEn;
    assign bus.o_window   = window;
    assign bus.o_valid    = valid;
    assign bus.o_busy     = busy;
    assign bus.dbgState   = state;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed and randomized bench for conv_window_fetch at RAM latencies 1 and 3.
module tb_conv_window_fetch;
    import conv_pkg::*;

    localparam int DW = 16;
    localparam int WW = DW * TAPS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    logic startS [2];
    logic [108:0] addrS [2];
    logic [11:0] ctrS [2];

    logic validS [2];
    logic busyS [2];
    logic rdEnS [2];
    logic [11:0] raddrS [2];
    logic [WW-1:0] winS [2];

    int nAssert = 0;
    int nFail = 0;

    conv_window_fetch_if #(.DATA_W(DW)) busA ();
    conv_window_fetch_if #(.DATA_W(DW)) busB ();

    conv_window_fetch #(.DATA_W(DW), .RAM_LAT(1)) dutA (
        .i_clk   (clk),
        .i_reset (rstN),
        .bus     (busA.slave)
    );

    conv_window_fetch #(.DATA_W(DW), .RAM_LAT(3)) dutB (
        .i_clk   (clk),
        .i_reset (rstN),
        .bus     (busB.slave)
    );

    assign busA.i_start     = startS[0];
    assign busA.i_addrRead  = addrS[0];
    assign busA.i_localAddr = ctrS[0];
    assign busB.i_start     = startS[1];
    assign busB.i_addrRead  = addrS[1];
    assign busB.i_localAddr = ctrS[1];

    assign validS[0] = busA.o_valid;
    assign validS[1] = busB.o_valid;
    assign busyS[0]  = busA.o_busy;
    assign busyS[1]  = busB.o_busy;
    assign rdEnS[0]  = busA.o_ramRdEn;
    assign rdEnS[1]  = busB.o_ramRdEn;
    assign raddrS[0] = busA.o_ramAddr;
    assign raddrS[1] = busB.o_ramAddr;
    assign winS[0]   = busA.o_window;
    assign winS[1]   = busB.o_window;

    // Source RAM holds mem[a] = a+1; unread cycles return a marker value.
    logic [15:0] ramA;
    logic [15:0] ramB [3];
    always @(posedge clk) begin
        ramA    <= busA.o_ramRdEn ? 16'(busA.o_ramAddr) + 16'd1 : 16'hDEAD;
        ramB[0] <= busB.o_ramRdEn ? 16'(busB.o_ramAddr) + 16'd1 : 16'hDEAD;
        ramB[1] <= ramB[0];
        ramB[2] <= ramB[1];
    end
    assign busA.i_ramData = ramA;
    assign busB.i_ramData = ramB[2];

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tap k looks at pixel (row + k/3 - 1, col + k%3 - 1); outside the 64x64 image it pads.
    function automatic logic padRef(input int k, input logic [11:0] ctr);
`ifdef CONV_WINDOW_PAD_EN
        int r;
        int c;
        r = int'(ctr[11:6]) + k / 3 - 1;
        c = int'(ctr[5:0]) + k % 3 - 1;
        return (r < 0) || (r > 63) || (c < 0) || (c > 63);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [WW-1:0] modelWindow(input logic [11:0] ctr, input logic [107:0] addrs);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (!padRef(k, ctr)) w[DW*k +: DW] = 16'(addrs[12*k +: 12]) + 16'd1;
        end
        return w;
    endfunction

    function automatic logic [107:0] geomAddrs(input logic [11:0] ctr);
        logic [107:0] a;
        int v;
        for (int k = 0; k < TAPS; k++) begin
            v = int'(ctr) + (k / 3 - 1) * 64 + (k % 3 - 1);
            a[12*k +: 12] = 12'(v & 4095);
        end
        return a;
    endfunction

    // mode 0: plain fetch, 1: start re-pulsed in cycles 3 and 8, 2: reset in cycle 5,
    // 3: second start in the cycle after the first o_valid.
    task automatic doFetch(input int inst, input logic [11:0] ctr, input logic [107:0] addrs, input int mode);
        int lat;
        int nValid;
        int vc [2];
        logic [WW-1:0] vw [2];
        logic [WW-1:0] expW;
        logic expEn;
        lat = (inst == 0) ? 1 : 3;
        nValid = 0;
        vc[0] = -1;
        vc[1] = -1;
        vw[0] = '0;
        vw[1] = '0;
        expW = modelWindow(ctr, addrs);
        @(posedge clk);
        #1;
        ctrS[inst] = ctr;
        addrS[inst] = {1'($urandom_range(0, 1)), addrs};
        startS[inst] = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            startS[inst] = (mode == 1 && (cyc == 3 || cyc == 8)) ||
                           (mode == 3 && nValid == 1 && cyc == vc[0] + 1);
            rstN = !(mode == 2 && cyc == 5);
            if (cyc <= 9 && !(mode == 2 && cyc > 5)) begin
                expEn = !padRef(cyc - 1, ctr);
                chk($sformatf("rden_tap%0d", cyc - 1), WW'(rdEnS[inst]), WW'(expEn));
                chk($sformatf("addr_tap%0d", cyc - 1), WW'(raddrS[inst]), WW'(addrs[12*(cyc-1) +: 12]));
            end
            if (cyc == 1) chk("win_cleared", winS[inst], '0);
            if (cyc == 5) chk("busy_mid", WW'(busyS[inst]), WW'(1'b1));
            if (mode == 2 && cyc == 6) begin
                chk("rst_busy", WW'(busyS[inst]), '0);
                chk("rst_win", winS[inst], '0);
                chk("rst_valid", WW'(validS[inst]), '0);
            end
            if (validS[inst]) begin
                if (nValid < 2) begin
                    vc[nValid] = cyc;
                    vw[nValid] = winS[inst];
                end
                nValid++;
            end
        end
        rstN = 1'b1;
        chk("valid_count", WW'(nValid), WW'((mode == 2) ? 0 : (mode == 3) ? 2 : 1));
        if (mode != 2) begin
            chk("valid_cycle", WW'(vc[0]), WW'(10 + lat));
            chk("window", vw[0], expW);
        end
        if (mode == 3) begin
            chk("b2b_cycle", WW'(vc[1]), WW'(21 + 2 * lat));
            chk("b2b_window", vw[1], expW);
        end
        chk("idle_busy", WW'(busyS[inst]), '0);
        chk("win_hold", winS[inst], (mode == 2) ? '0 : expW);
    endtask

    initial begin
        logic [11:0] ctr;
        logic [107:0] addrs;
        int inst;
        rstN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            startS[i] = 1'b0;
            addrS[i] = '0;
            ctrS[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Start presented while reset is held: reset must win.
        startS[0] = 1'b1;
        startS[1] = 1'b1;
        @(posedge clk);
        #1;
        startS[0] = 1'b0;
        startS[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", WW'(validS[i]), '0);
            chk("rst_busy", WW'(busyS[i]), '0);
            chk("rst_window", winS[i], '0);
            chk("rst_ramaddr", WW'(raddrS[i]), '0);
            chk("rst_rden", WW'(rdEnS[i]), '0);
        end
        chk("rst_state", WW'(busA.dbgState), WW'(IDLE));
        rstN = 1'b1;
        @(posedge clk);
        #1;
        chk("no_start_after_rst", WW'(busyS[0]), '0);

        doFetch(0, 12'd2080, geomAddrs(12'd2080), 0);
        doFetch(1, 12'd2080, geomAddrs(12'd2080), 0);
        doFetch(0, 12'd0, geomAddrs(12'd0), 0);
        doFetch(0, 12'd4095, geomAddrs(12'd4095), 0);
        doFetch(0, 12'd2080, geomAddrs(12'd2080), 1);
        doFetch(1, 12'd63, geomAddrs(12'd63), 1);
        doFetch(0, 12'd2080, geomAddrs(12'd2080), 2);
        doFetch(0, 12'd4032, geomAddrs(12'd4032), 0);
        doFetch(1, 12'd1000, geomAddrs(12'd1000), 2);
        doFetch(1, 12'd2080, geomAddrs(12'd2080), 0);
        doFetch(0, 12'd130, geomAddrs(12'd130), 3);
        doFetch(1, 12'd4095, geomAddrs(12'd4095), 3);

        for (int n = 0; n < 8; n++) begin
            inst = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: ctr = {6'($urandom_range(0, 1) * 63), 6'($urandom_range(0, 63))};
                1: ctr = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 1) * 63)};
                default: ctr = 12'($urandom_range(0, 4095));
            endcase
            if (n % 2 == 0) begin
                addrs = geomAddrs(ctr);
            end else begin
                for (int k = 0; k < TAPS; k++) addrs[12*k +: 12] = 12'($urandom_range(0, 4095));
            end
            doFetch(inst, ctr, addrs, int'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/conv_window_fetch.md
# conv_window_fetch

Fetches the 3x3 neighbourhood for one output pixel from a 64x64 feature-map RAM and presents it as a packed 9-tap window to the convolution datapath. Sits between the convolution controller and the source RAM. It consumes the controller's `i_start` pulse and nine packed tap addresses, issues nine sequential single-port reads, zero-pads taps that fall outside the image, and answers with a one-cycle `o_valid`, which the controller uses as its RAM-valid handshake.

## Interface
- `DATA_W`, 16: pixel width.
- `RAM_LAT`, 1: source-RAM read latency in cycles, legal range 1..4.
- `i_clk`  input  1  clock.
- `i_reset`  input  1  **single clock; reset is synchronous and active-low.**
- `i_start`  input  1  fetch request, from the controller's start-RAM pulse.
- `i_addrRead`  input  109  nine 12-bit tap addresses; tap k at bits [12k+11:12k], bit 108 unused.
- `i_localAddr`  input  12  centre address, `{row[5:0], col[5:0]}`.
- `o_ramAddr`  output  12  source-RAM read address.
- `o_ramRdEn`  output  1  source-RAM read enable.
- `i_ramData`  input  DATA_W  read data, valid RAM_LAT cycles after `o_ramRdEn`.
- `o_window`  output  9*DATA_W  tap k at bits [DATA_W*k +: DATA_W].
- `o_valid`  output  1  one-cycle pulse: window complete.
- `o_busy`  output  1  high from the cycle after start acceptance until `o_valid`.

## Operation
- States:
  - IDLE: wait for `i_start`.
  - ISSUE: taps 0..8, one per cycle, 4-bit tap counter.
  - DRAIN: RAM_LAT cycles.
  - DONE: one cycle, `o_valid`=1, then IDLE.
- `i_start` is sampled only in IDLE. When accepted, the block latches `i_addrRead` and `i_localAddr` and clears `o_window` to 0. `i_start` in any other state is ignored.
- Tap k geometry:
  - dr = k/3 - 1, dc = k%3 - 1.
  - Tap k is out-of-image when (row==0 & dr<0) | (row==63 & dr>0) | (col==0 & dc<0) | (col==63 & dc>0).
- ISSUE cycle k:
  - `o_ramAddr` = latched tap k address.
  - `o_ramRdEn` = 1 unless tap k is out-of-image.
- A RAM_LAT-deep delay line carries {live, tap index, pad} for each issued tap.
  - At its output, a live non-pad entry writes `i_ramData` into slot `tap`.
  - A pad entry writes 0 into slot `tap`.
- `o_window` holds its value from DONE until the next accepted start.
- Address arithmetic is modulo 4096. The block does not recompute tap addresses; it uses the supplied ones.

## Timing
- Reset values, applied at the first clock edge with `i_reset`=0:
  - state = IDLE.
  - `o_ramAddr` = 0, `o_ramRdEn` = 0, `o_window` = 0, `o_valid` = 0, `o_busy` = 0.
  - Delay line flushed.
- `o_ramAddr` and `o_ramRdEn` are combinational from state and tap counter. `o_window`, `o_valid` and `o_busy` are registered.
- Cycle numbering: cycle 0 is the cycle in which `i_start` is sampled.
  - Tap k is on the RAM bus in cycle k+1.
  - `o_valid` is high in cycle 10+RAM_LAT (cycle 11 at the default).
- Back-to-back: a start in the cycle after DONE is accepted, giving 11+RAM_LAT cycles per window.
- Reset asserted mid-ISSUE or mid-DRAIN: at the next edge the block returns to IDLE, clears outputs and discards in-flight reads. No `o_valid` is produced for the aborted fetch.
- `i_start` together with `i_reset`=0: reset wins.

## Configuration
- `CONV_WINDOW_PAD_EN` defined: boundary zero-padding as described, with `o_ramRdEn` suppressed for pad taps.
- `CONV_WINDOW_PAD_EN` undefined:
  - No pad logic is compiled.
  - All nine taps are read at the supplied addresses, including wrapped ones.
  - `o_ramRdEn`=1 for all nine ISSUE cycles.
  - `i_localAddr` is unused.

## Structure
- Shared package `conv_pkg` holds:
  - IMG_W=64, IMG_LOG2=6, ADDR_W=12, TAPS=9.
  - State encoding localparams.
  - Tap row/column offset constants.
- Sub-module `conv_window_delay`: RAM_LAT-deep shift register of {live, tap[3:0], pad}, flushed on reset.

## Test plan
All scenarios use RAM contents mem[a] = a+1 and RAM_LAT=1 unless stated.
- Interior pixel, centre 2080, addresses centre+{-65,-64,-63,-1,0,1,63,64,65} -> taps 0..8 = 2016,2017,2018,2080,2081,2082,2144,2145,2146. `o_valid` pulses in cycle 11 only.
- PAD_EN, centre 0 -> taps 0,1,2,3,6 = 0; tap4=1, tap5=2, tap7=65, tap8=66. `o_ramRdEn` low in the 5 pad cycles.
- PAD_EN undefined, centre 4095 -> tap8 address wraps to 64, data 65. `o_ramRdEn` high for 9 cycles.
- `i_start` re-pulsed in cycles 3 and 8 -> exactly one `o_valid`, window unchanged from the single-start result.
- `i_reset`=0 in cycle 5 -> `o_busy`=0, `o_window`=0 and `o_valid`=0 next cycle. A new start completes normally.
- RAM_LAT=3, interior pixel -> same window as the first scenario, `o_valid` in cycle 13.
